// File: rtl/gs_ddram_bridge.sv
// GS byte-wide memory port bridged onto a 64-bit DDRAM channel, with a one-line
// write-through read cache so that sequential byte reads within a word skip DDRAM.
module gs_ddram_bridge #(
    parameter logic [28:0] BASE_WADDR = 29'h0600_0000
) (
    input  logic        clk_sys,
    input  logic        reset_n,

    input  logic [20:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        rd,
    input  logic        we,
    output logic        ready,

    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StWrReq} state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic [7:0]  dout_q, dout_d;
    logic [20:0] last_addr_q, last_addr_d;
    logic [7:0]  din_q, din_d;
    logic        req_prev_q;
    logic        valid_q, valid_d;
    logic [17:0] tag_q, tag_d;
    logic [63:0] data_q, data_d;

    logic new_req;
    logic rd_hit;
    logic wr_hit;

    // A request is new on a rising request level or on an address change under a held level.
    assign new_req = (rd | we) && (!req_prev_q || addr != last_addr_q);
    assign rd_hit  = valid_q && (tag_q == addr[20:3]);
    assign wr_hit  = valid_q && (tag_q == last_addr_q[20:3]);

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        dout_d      = dout_q;
        last_addr_d = last_addr_q;
        din_d       = din_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;

        case (state_q)
            StIdle: begin
                if (new_req) begin
                    last_addr_d = addr;
                    din_d       = din;
                    if (we) begin
                        ready_d = 1'b0;
                        state_d = StWrReq;
                    end else if (rd_hit) begin
                        dout_d = data_q[{addr[2:0], 3'b000} +: 8];
                    end else begin
                        ready_d = 1'b0;
                        state_d = StRdReq;
                    end
                end
            end
            StRdReq: begin
                if (!DDRAM_BUSY) state_d = StRdWait;
            end
            StRdWait: begin
                if (DDRAM_DOUT_READY) begin
                    tag_d   = last_addr_q[20:3];
                    data_d  = DDRAM_DOUT;
                    valid_d = 1'b1;
                    dout_d  = DDRAM_DOUT[{last_addr_q[2:0], 3'b000} +: 8];
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrReq: begin
                if (!DDRAM_BUSY) begin
                    // Write-through: patch the cached line only on a hit, never allocate.
                    if (wr_hit) data_d[{last_addr_q[2:0], 3'b000} +: 8] = din_q;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            dout_q      <= 8'hFF;
            last_addr_q <= '0;
            din_q       <= '0;
            req_prev_q  <= 1'b0;
            valid_q     <= 1'b0;
            tag_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            dout_q      <= dout_d;
            last_addr_q <= last_addr_d;
            din_q       <= din_d;
            req_prev_q  <= rd | we;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
        end
    end

    assign dout           = dout_q;
    assign ready          = ready_q;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = BASE_WADDR + {11'b0, last_addr_q[20:3]};
    assign DDRAM_RD       = (state_q == StRdReq);
    assign DDRAM_WE       = (state_q == StWrReq);
    assign DDRAM_DIN      = (state_q == StWrReq) ? {8{din_q}} : 64'h0;
    assign DDRAM_BE       = (state_q == StWrReq) ? (8'b1 << last_addr_q[2:0]) : 8'h00;

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Directed bench for gs_ddram_bridge: cold miss, cache hit, write-through with a busy
// DDRAM, rd/we priority, reset during a read and repeated-address suppression.
module tb_gs_ddram_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [20:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        we;
    logic        ready;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    int vectors = 0;
    int miscompares = 0;
    int rd_cycles = 0;
    int we_cycles = 0;
    int rd_mark;
    int we_mark;

    gs_ddram_bridge #(.BASE_WADDR(29'h0600_0000)) dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .addr             (addr),
        .din              (din),
        .dout             (dout),
        .rd               (rd),
        .we               (we),
        .ready            (ready),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_WE         (DDRAM_WE)
    );

    always #5 clk_sys = ~clk_sys;

    // Count clock edges at which each DDRAM strobe is seen high.
    always @(posedge clk_sys) begin
        if (DDRAM_RD === 1'b1) rd_cycles = rd_cycles + 1;
        if (DDRAM_WE === 1'b1) we_cycles = we_cycles + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; addr = '0; din = '0; rd = 0; we = 0;
        DDRAM_BUSY = 0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 0;
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_dout", 64'(dout), 64'hFF);
        chk("rst_rd", 64'(DDRAM_RD), 64'd0);
        chk("rst_we", 64'(DDRAM_WE), 64'd0);
        chk("rst_be", 64'(DDRAM_BE), 64'h0);
        chk("rst_din", DDRAM_DIN, 64'h0);
        chk("rst_addr", 64'(DDRAM_ADDR), 64'h0600_0000);
        chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        reset_n = 1'b1;
        tick();

        // Cold read miss of byte 5.
        rd_mark = rd_cycles;
        rd = 1; addr = 21'h000005;
        tick();
        chk("miss_ready", 64'(ready), 64'd0);
        chk("miss_rdreq", 64'(DDRAM_RD), 64'd1);
        chk("miss_ddr_addr", 64'(DDRAM_ADDR), 64'h0600_0000);
        tick();
        chk("miss_rd_drop", 64'(DDRAM_RD), 64'd0);
        tick();
        tick();
        chk("miss_ready_wait", 64'(ready), 64'd0);
        DDRAM_DOUT = 64'h8877_6655_4433_2211; DDRAM_DOUT_READY = 1;
        tick();
        DDRAM_DOUT_READY = 0;
        chk("miss_dout", 64'(dout), 64'h66);
        chk("miss_ready_back", 64'(ready), 64'd1);
        chk("miss_rd_pulses", 64'(rd_cycles - rd_mark), 64'd1);

        // Hit on the same line, rd held high, new address.
        rd_mark = rd_cycles;
        addr = 21'h000002;
        tick();
        chk("hit_dout", 64'(dout), 64'h33);
        chk("hit_ready", 64'(ready), 64'd1);
        tick();
        chk("hit_no_rd", 64'(rd_cycles - rd_mark), 64'd0);

        // Write with DDRAM busy for 4 cycles.
        we_mark = we_cycles;
        rd = 0; we = 1; addr = 21'h000003; din = 8'hA5; DDRAM_BUSY = 1;
        tick();
        chk("wr_be", 64'(DDRAM_BE), 64'h08);
        chk("wr_din", DDRAM_DIN, 64'hA5A5_A5A5_A5A5_A5A5);
        din = 8'h00; addr = 21'h000011;
        for (int i = 0; i < 4; i++) begin
            chk("wr_we_held", 64'(DDRAM_WE), 64'd1);
            chk("wr_ready_low", 64'(ready), 64'd0);
            tick();
        end
        chk("wr_din_latched", DDRAM_DIN, 64'hA5A5_A5A5_A5A5_A5A5);
        DDRAM_BUSY = 0;
        tick();
        chk("wr_done_ready", 64'(ready), 64'd1);
        chk("wr_we_drop", 64'(DDRAM_WE), 64'd0);
        chk("wr_we_cycles", 64'(we_cycles - we_mark), 64'd5);
        we = 0;
        tick();
        rd_mark = rd_cycles;
        rd = 1; addr = 21'h000003;
        tick();
        chk("wr_hit_dout", 64'(dout), 64'hA5);
        chk("wr_hit_no_rd", 64'(rd_cycles - rd_mark), 64'd0);

        // rd and we rising together: write wins.
        rd = 0;
        tick();
        rd_mark = rd_cycles;
        rd = 1; we = 1; addr = 21'h1FFFFF; din = 8'h3C;
        tick();
        chk("prio_we", 64'(DDRAM_WE), 64'd1);
        chk("prio_rd", 64'(DDRAM_RD), 64'd0);
        chk("prio_addr", 64'(DDRAM_ADDR), 64'h0603_FFFF);
        chk("prio_be", 64'(DDRAM_BE), 64'h80);
        tick();
        chk("prio_ready", 64'(ready), 64'd1);
        chk("prio_no_rd", 64'(rd_cycles - rd_mark), 64'd0);
        rd = 0; we = 0;
        tick();

        // Reset during RD_WAIT, then a late DOUT_READY.
        rd = 1; addr = 21'h000010;
        tick();
        tick();
        chk("rw_in_wait", 64'(ready), 64'd0);
        reset_n = 0;
        #1;
        chk("rw_rst_ready", 64'(ready), 64'd1);
        chk("rw_rst_dout", 64'(dout), 64'hFF);
        rd = 0;
        tick();
        reset_n = 1;
        DDRAM_DOUT = 64'hDEAD_BEEF_CAFE_F00D; DDRAM_DOUT_READY = 1;
        tick();
        DDRAM_DOUT_READY = 0;
        chk("rw_late_ready", 64'(ready), 64'd1);
        chk("rw_late_dout", 64'(dout), 64'hFF);
        rd_mark = rd_cycles;
        rd = 1; addr = 21'h000010;
        tick();
        chk("rw_remiss_rd", 64'(DDRAM_RD), 64'd1);
        chk("rw_remiss_ready", 64'(ready), 64'd0);
        tick();
        DDRAM_DOUT = 64'h0102_0304_0506_0708; DDRAM_DOUT_READY = 1;
        tick();
        DDRAM_DOUT_READY = 0;
        chk("rw_refill_dout", 64'(dout), 64'h08);
        chk("rw_rd_pulses", 64'(rd_cycles - rd_mark), 64'd1);
        rd = 0;
        tick();

        // rd held while addr steps 0 -> 8 -> 8.
        rd_mark = rd_cycles;
        rd = 1; addr = 21'h000000;
        tick();
        tick();
        DDRAM_DOUT = 64'h1111_1111_1111_11C0; DDRAM_DOUT_READY = 1;
        tick();
        DDRAM_DOUT_READY = 0;
        chk("step0_dout", 64'(dout), 64'hC0);
        addr = 21'h000008;
        tick();
        chk("step8_rd", 64'(DDRAM_RD), 64'd1);
        tick();
        DDRAM_DOUT = 64'h2222_2222_2222_22C8; DDRAM_DOUT_READY = 1;
        tick();
        DDRAM_DOUT_READY = 0;
        chk("step8_dout", 64'(dout), 64'hC8);
        addr = 21'h000008;
        tick();
        tick();
        tick();
        chk("step8_again_ready", 64'(ready), 64'd1);
        chk("step_rd_pulses", 64'(rd_cycles - rd_mark), 64'd2);
        rd = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
